// File: rtl/prog_mem_responder.sv
// Word-addressed program memory that answers CPU fetches with a fixed read latency.
// Out-of-range reads return HALT_WORD. A loader port fills the memory while the CPU is held in reset.
module prog_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] HALT_WORD   = 32'h00100073,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        rd_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        ld_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  CNT_INIT = 2'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_oor;
  logic          r_pend;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_rd_err;
  logic          r_ld_err;

  logic [AW-1:0] w_rd_idx;
  logic          w_rd_oor;
  logic [AW-1:0] w_ld_idx;
  logic          w_ld_oor;
  logic          w_ld_fire;

  assign w_rd_idx  = mem_addr[AW+1:2];
  assign w_rd_oor  = (mem_addr >= LIMIT);
  assign w_ld_idx  = ld_addr[AW+1:2];
  assign w_ld_oor  = (ld_addr >= LIMIT);
  assign ld_ready  = (r_state == S_IDLE) & ~mem_rstrb & ~rst;
  assign w_ld_fire = ld_valid & ld_ready;

  always_ff @(posedge clk) begin
    if (w_ld_fire && !w_ld_oor) r_mem[w_ld_idx] <= ld_data;
  end

  // r_pend marks the final latency cycle; it is shared by the LATENCY=1 path and
  // the BUSY exit so every read completes exactly LATENCY edges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_oor    <= 1'b0;
      r_pend   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rd_err <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rd_err <= 1'b0;
      r_pend   <= 1'b0;
      r_ld_err <= w_ld_fire & w_ld_oor;
      if (r_pend) begin
        r_rdata  <= r_oor ? HALT_WORD : r_mem[r_idx];
        r_rvalid <= 1'b1;
        r_rd_err <= r_oor;
      end
      case (r_state)
        S_IDLE: begin
          if (mem_rstrb) begin
            r_idx <= w_rd_idx;
            r_oor <= w_rd_oor;
            if (LATENCY == 1) begin
              r_pend <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= 2'(r_cnt - 2'd1);
          end else begin
            r_state <= S_IDLE;
            r_pend  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rdata  = r_rdata;
  assign mem_rvalid = r_rvalid;
  assign rd_err     = r_rd_err;
  assign ld_err     = r_ld_err;
  assign busy       = (r_state == S_BUSY);

endmodule
